// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and helpers for the instruction-fetch stage.
//   INSTR_W          : instruction / address width
//   NOP_INSTR        : bubble word loaded into IF/ID on a squash
//   RESET_PC_DEFAULT : default PC after reset (word aligned)
//   PC_STEP          : sequential PC increment in bytes
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int                 INSTR_W          = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] PC_STEP          = 32'd4;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [INSTR_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Bundles the fetch-stage control inputs, the instruction-memory read port and
// the IF/ID outputs.
//   master : the fetch unit (drives im_addr, pc, IF/ID, status, counters)
//   slave  : the surroundings (hazard unit, ID stage, instruction memory)
// Signals:
//   stall, flush, br_taken, br_target, jmp, jmp_target : redirect / hazard ctl
//   im_addr -> / <- im_data                            : combinational imem read
//   pc, ifid_instr, ifid_pc4, ifid_valid               : stage state
//   align_err, fetch_cnt, stall_cnt                    : status / perf counters
// -----------------------------------------------------------------------------
interface if_fetch_unit_if #(
    parameter int W = cpu_pkg::INSTR_W
);
    logic         stall;
    logic         flush;
    logic         br_taken;
    logic [W-1:0] br_target;
    logic         jmp;
    logic [W-1:0] jmp_target;
    logic [W-1:0] im_addr;
    logic [W-1:0] im_data;
    logic [W-1:0] pc;
    logic [W-1:0] ifid_instr;
    logic [W-1:0] ifid_pc4;
    logic         ifid_valid;
    logic         align_err;
    logic [31:0]  fetch_cnt;
    logic [31:0]  stall_cnt;

    modport master (
        input  stall, flush, br_taken, br_target, jmp, jmp_target, im_data,
        output im_addr, pc, ifid_instr, ifid_pc4, ifid_valid, align_err,
               fetch_cnt, stall_cnt
    );

    modport slave (
        output stall, flush, br_taken, br_target, jmp, jmp_target, im_data,
        input  im_addr, pc, ifid_instr, ifid_pc4, ifid_valid, align_err,
               fetch_cnt, stall_cnt
    );
endinterface

// File: rtl/if_fetch_unit_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter with next-PC selection and redirect-target alignment.
// Ports:
//   clk, rst       : clock, async active-high reset
//   i_stall        : hold PC (ignored when a redirect is present)
//   i_br_taken     : take i_br_target (highest priority)
//   i_br_target    : branch target byte address
//   i_jmp          : take i_jmp_target
//   i_jmp_target   : jump target byte address
//   o_pc           : current PC
//   o_align_err    : sticky, set when a selected target had nonzero bits [1:0]
// -----------------------------------------------------------------------------
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_stall,
    input  logic               i_br_taken,
    input  logic [INSTR_W-1:0] i_br_target,
    input  logic               i_jmp,
    input  logic [INSTR_W-1:0] i_jmp_target,
    output logic [INSTR_W-1:0] o_pc,
    output logic               o_align_err
);

    logic [INSTR_W-1:0] r_pc;
    logic               r_align_err;
    logic               w_redirect;
    logic [INSTR_W-1:0] w_target;
    logic [INSTR_W-1:0] w_pc_next;
    logic               w_misaligned;

    assign w_redirect   = i_br_taken | i_jmp;
    assign w_target     = i_br_taken ? i_br_target : i_jmp_target;
    // Only the target actually selected can raise the alignment error.
    assign w_misaligned = w_redirect & is_misaligned(w_target);

    // Redirects beat stall; the sequential add wraps naturally at 2^32.
    always_comb begin
        w_pc_next = r_pc + PC_STEP;
        if (w_redirect) begin
            w_pc_next = word_align(w_target);
        end else if (i_stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_align_err <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_misaligned) begin
                r_align_err <= 1'b1;
            end
        end
    end

    assign o_pc        = r_pc;
    assign o_align_err = r_align_err;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: drives the PC onto the combinational instruction
// memory port and captures the returned word into the IF/ID register.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : if_fetch_unit_if.master (controls, imem port, IF/ID, status)
// Optional feature macro FETCH_PERF_EN:
//   defined   -> fetch_cnt / stall_cnt are live 32-bit wrapping counters
//   undefined -> both read as zero and no counter flops exist
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
    parameter int          INSTR_W  = cpu_pkg::INSTR_W
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_unit_if.master bus
);
    import cpu_pkg::*;

    logic [INSTR_W-1:0] w_pc;
    logic [INSTR_W-1:0] w_pc4;
    logic               w_redirect;
    logic               w_squash;
    logic               w_load;

    logic [INSTR_W-1:0] r_ifid_instr;
    logic [INSTR_W-1:0] r_ifid_pc4;
    logic               r_ifid_valid;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .i_stall      (bus.stall),
        .i_br_taken   (bus.br_taken),
        .i_br_target  (bus.br_target),
        .i_jmp        (bus.jmp),
        .i_jmp_target (bus.jmp_target),
        .o_pc         (w_pc),
        .o_align_err  (bus.align_err)
    );

    assign w_pc4      = w_pc + PC_STEP;
    assign w_redirect = bus.br_taken | bus.jmp;
    // No delay slot: the word fetched alongside a redirect is squashed.
    assign w_squash   = bus.flush | w_redirect;
    assign w_load     = ~w_squash & ~bus.stall;

    // Squash leaves ifid_pc4 untouched; only instr/valid form the bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc4   <= '0;
            r_ifid_valid <= 1'b0;
        end else if (w_squash) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (w_load) begin
            r_ifid_instr <= bus.im_data;
            r_ifid_pc4   <= w_pc4;
            r_ifid_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_load) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (bus.stall && !w_redirect) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign bus.fetch_cnt = r_fetch_cnt;
    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.fetch_cnt = 32'h0;
    assign bus.stall_cnt = 32'h0;
`endif

    assign bus.pc         = w_pc;
    assign bus.im_addr    = w_pc;
    assign bus.ifid_instr = r_ifid_instr;
    assign bus.ifid_pc4   = r_ifid_pc4;
    assign bus.ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed program walk followed by randomized control traffic, checked
// against a behavioural model of the fetch stage kept in this bench.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    if_fetch_unit_if bus ();

    if_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Standard 11-word program at byte addresses 0x00..0x28; all else reads 0.
    logic [31:0] prog [11] = '{
        32'h2010_0000, 32'h2011_0000, 32'h0000_9024, 32'h2008_000a,
        32'h1228_0004, 32'h0212_9020, 32'h2210_0001, 32'h2108_ffff,
        32'h0800_0004, 32'hac12_0000, 32'h1000_ffff
    };

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a < 32'd44 && a[1:0] == 2'b00) return prog[a >> 2];
        return 32'h0;
    endfunction

    always_comb bus.im_data = imem(bus.im_addr);

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4, m_fcnt, m_scnt;
    logic        m_valid, m_align;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_align = 1'b0; m_fcnt = 32'h0; m_scnt = 32'h0;
    endtask

    // One clock edge of the fetch stage, from the written rules.
    task automatic model_edge(input logic s, input logic f, input logic b,
                              input logic [31:0] bt, input logic j, input logic [31:0] jt);
        logic [31:0] old_pc, tgt;
        logic        redir;
        old_pc = m_pc;
        redir  = b | j;
        tgt    = b ? bt : jt;
        if (redir) begin
            m_pc = (tgt / 4) * 4;
            if (tgt % 4 != 0) m_align = 1'b1;
        end else if (!s) begin
            m_pc = old_pc + 32'd4;
        end
        if (f || redir) begin
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else if (!s) begin
            m_instr = imem(old_pc);
            m_pc4   = old_pc + 32'd4;
            m_valid = 1'b1;
            m_fcnt  = m_fcnt + 32'd1;
        end
        if (s && !redir) m_scnt = m_scnt + 32'd1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},      bus.pc,         m_pc);
        chk({tag, ".im_addr"}, bus.im_addr,    m_pc);
        chk({tag, ".instr"},   bus.ifid_instr, m_instr);
        chk({tag, ".pc4"},     bus.ifid_pc4,   m_pc4);
        chk({tag, ".valid"},   {31'h0, bus.ifid_valid}, {31'h0, m_valid});
        chk({tag, ".align"},   {31'h0, bus.align_err},  {31'h0, m_align});
`ifdef FETCH_PERF_EN
        chk({tag, ".fcnt"},    bus.fetch_cnt,  m_fcnt);
        chk({tag, ".scnt"},    bus.stall_cnt,  m_scnt);
`else
        chk({tag, ".fcnt"},    bus.fetch_cnt,  32'h0);
        chk({tag, ".scnt"},    bus.stall_cnt,  32'h0);
`endif
    endtask

    // Called between edges; drives inputs, takes one edge, checks #1 later.
    task automatic step(input string tag, input logic s, input logic f,
                        input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt);
        bus.stall = s; bus.flush = f; bus.br_taken = b; bus.br_target = bt;
        bus.jmp = j; bus.jmp_target = jt;
        @(posedge clk);
        #1;
        model_edge(s, f, b, bt, j, jt);
        check_all(tag);
    endtask

    task automatic run(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic async_reset(input string tag);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 rst = 1'b0;
    endtask

    logic [31:0] r_bt, r_jt;
    logic        r_s, r_f, r_b, r_j;

    initial begin
        bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0;
        bus.br_target = 32'h0; bus.jmp = 1'b0; bus.jmp_target = 32'h0;
        model_reset();

        #2 check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        #1 check_all("release");

        run("e1");
        chk("e1.instr_const", bus.ifid_instr, 32'h2010_0000);
        chk("e1.pc4_const",   bus.ifid_pc4,   32'h0000_0004);
        chk("e1.pc_const",    bus.pc,         32'h0000_0004);
        run("e2");
        chk("e2.instr_const", bus.ifid_instr, 32'h2011_0000);
        run("e3");
        chk("e3.instr_const", bus.ifid_instr, 32'h0000_9024);
        run("e4");
        chk("e4.instr_const", bus.ifid_instr, 32'h2008_000a);
        chk("e4.pc_const",    bus.pc,         32'h0000_0010);

        for (int i = 0; i < 5; i++) run("walk");
        chk("walk.pc_const", bus.pc, 32'h0000_0024);

        step("jmp", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0010);
        chk("jmp.pc_const",    bus.pc,         32'h0000_0010);
        chk("jmp.valid_const", {31'h0, bus.ifid_valid}, 32'h0);
        run("after_jmp");
        chk("after_jmp.instr_const", bus.ifid_instr, 32'h1228_0004);
        chk("after_jmp.pc_const",    bus.pc,         32'h0000_0014);

        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("stall.pc_const",    bus.pc,         32'h0000_0014);
            chk("stall.instr_const", bus.ifid_instr, 32'h1228_0004);
        end
        run("resume");
        chk("resume.instr_const", bus.ifid_instr, 32'h0212_9020);

        step("stall_flush", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stall_flush.pc_const",    bus.pc, 32'h0000_0018);
        chk("stall_flush.valid_const", {31'h0, bus.ifid_valid}, 32'h0);

        step("br_mis", 1'b0, 1'b0, 1'b1, 32'h0000_0026, 1'b0, 32'h0);
        chk("br_mis.pc_const",    bus.pc, 32'h0000_0024);
        chk("br_mis.align_const", {31'h0, bus.align_err}, 32'h1);
        run("sticky");
        run("sticky");
        chk("sticky.align_const", {31'h0, bus.align_err}, 32'h1);

        step("br_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        run("wrap");
        chk("wrap.pc_const", bus.pc, 32'h0000_0000);
        run("post_wrap");

        async_reset("async_rst");
        chk("async_rst.pc_const", bus.pc, 32'h0000_0000);

        for (int i = 0; i < 400; i++) begin
            r_s = ($urandom_range(0, 3) == 0);
            r_f = ($urandom_range(0, 9) == 0);
            r_b = ($urandom_range(0, 9) == 0);
            r_j = ($urandom_range(0, 9) == 0);
            r_bt = $urandom_range(0, 15) * 4;
            r_jt = $urandom_range(0, 15) * 4;
            if ($urandom_range(0, 7) == 0) r_bt = r_bt | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) r_jt = r_jt | $urandom_range(0, 3);
            if ($urandom_range(0, 31) == 0) r_bt = 32'hFFFF_FFF8;
            step("rand", r_s, r_f, r_b, r_bt, r_j, r_jt);
            if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
